// File: rtl/bcd_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// BcdSerialAddCtrl: bcd_serial_add_ctrl
//
// Adds two NDIGITS-digit packed-BCD operands with one shared one-digit BCD
// add stage. One digit is processed per clock, least significant digit first.
// Operands are captured on accept. The registered sum and carry are published
// on the edge that enters DONE.
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   reset  in   synchronous active-high reset
//   start  in   request, only looked at while ready=1
//   a, b   in   4*NDIGITS packed-BCD addends, digit i at [4i+3:4i]
//   cin    in   carry into digit 0
//   ready  out  a start will be accepted this cycle (IDLE or DONE)
//   busy   out  addition in progress (RUN)
//   done   out  one-cycle pulse, s/cout valid from this cycle on
//   s      out  registered BCD sum
//   cout   out  registered carry out of the top digit
//   err    out  only when BCD_SERIAL_CHECK_EN is defined: an operand of the
//               last addition held a digit greater than 9
//
// Optional build macro: BCD_SERIAL_CHECK_EN (adds err and operand checking).
// ----------------------------------------------------------------------------
module bcd_serial_add_ctrl #(
    parameter int NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*NDIGITS-1:0] a,
    input  logic [4*NDIGITS-1:0] b,
    input  logic                 cin,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*NDIGITS-1:0] s,
    output logic                 cout
`ifdef BCD_SERIAL_CHECK_EN
    ,
    output logic                 err
`endif
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic [W-1:0]  aWork_q,   aWork_d;
    logic [W-1:0]  bWork_q,   bWork_d;
    logic [W-1:0]  sumWork_q, sumWork_d;
    logic          carry_q,   carry_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [W-1:0]  s_q,       s_d;
    logic          cout_q,    cout_d;

    logic [4:0]    digitSum;
    logic [4:0]    digitAdj;
    logic [3:0]    digitOut;
    logic          digitCarry;
    logic [W+3:0]  sumConcat;
    logic [W-1:0]  sumShifted;

`ifdef BCD_SERIAL_CHECK_EN
    logic          errFlag_q, errFlag_d;
    logic          err_q,     err_d;
    logic          opInvalid;
`endif

    // One-digit BCD add on the low digits of the working operands. The
    // subtract-10 correction is applied to the raw 5-bit sum, so digits
    // above 9 give a deterministic (non-BCD) result rather than an error.
    always_comb begin
        digitSum   = {1'b0, aWork_q[3:0]} + {1'b0, bWork_q[3:0]} + {4'd0, carry_q};
        digitAdj   = digitSum - 5'd10;
        digitOut   = digitSum[3:0];
        digitCarry = 1'b0;
        if (digitSum >= 5'd10) begin
            digitOut   = digitAdj[3:0];
            digitCarry = 1'b1;
        end
        // New digit enters at the MSB end; after NDIGITS shifts the first
        // digit produced has walked down to the LSB position.
        sumConcat  = {digitOut, sumWork_q};
        sumShifted = sumConcat[W+3:4];
    end

`ifdef BCD_SERIAL_CHECK_EN
    // Flags any operand digit outside 0..9 at accept time.
    always_comb begin
        opInvalid = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                opInvalid = 1'b1;
            end
        end
    end
`endif

    // Control FSM and datapath next-state. IDLE and DONE behave identically
    // on start so back-to-back requests need no idle bubble. s/cout only
    // change on the RUN->DONE edge so they hold across the next operation.
    always_comb begin
        state_d   = state_q;
        aWork_d   = aWork_q;
        bWork_d   = bWork_q;
        sumWork_d = sumWork_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        cout_d    = cout_q;
`ifdef BCD_SERIAL_CHECK_EN
        errFlag_d = errFlag_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    aWork_d   = a;
                    bWork_d   = b;
                    sumWork_d = '0;
                    carry_d   = cin;
                    cnt_d     = '0;
                    state_d   = RUN;
`ifdef BCD_SERIAL_CHECK_EN
                    errFlag_d = opInvalid;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                aWork_d   = aWork_q >> 4;
                bWork_d   = bWork_q >> 4;
                sumWork_d = sumShifted;
                carry_d   = digitCarry;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = sumShifted;
                    cout_d  = digitCarry;
                    state_d = DONE;
`ifdef BCD_SERIAL_CHECK_EN
                    err_d   = errFlag_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins over everything including a running add.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            aWork_q   <= '0;
            bWork_q   <= '0;
            sumWork_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            s_q       <= '0;
            cout_q    <= 1'b0;
`ifdef BCD_SERIAL_CHECK_EN
            errFlag_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            aWork_q   <= aWork_d;
            bWork_q   <= bWork_d;
            sumWork_q <= sumWork_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            cout_q    <= cout_d;
`ifdef BCD_SERIAL_CHECK_EN
            errFlag_q <= errFlag_d;
            err_q     <= err_d;
`endif
        end
    end

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign s     = s_q;
    assign cout  = cout_q;
`ifdef BCD_SERIAL_CHECK_EN
    assign err   = err_q;
`endif

endmodule
